// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: turns stall/flush requests into PC and pipeline-register
// enables with zero latency, and tracks stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned STALL_MAX = 255,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_stall,
    input  logic             flush,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       ctrl_state,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0]       FLUSH_LOAD  = 4'(FLUSH_LEN - 1);
    localparam logic [8:0]       STALL_LIMIT = 9'(STALL_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        fcnt_r;
    logic [3:0]        fcnt_next_s;
    logic [7:0]        scnt_r;
    logic [7:0]        scnt_next_s;
    logic              timeout_r;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic [CNT_W-1:0]  flush_events_r;
    logic              stall_apply_s;
    logic              flush_apply_s;
    logic              timeout_set_s;

    // Next-state, counter updates and the zero-latency control outputs
    always_comb begin
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        state_next_s  = RUN;
        fcnt_next_s   = 4'd0;
        scnt_next_s   = 8'd0;
        stall_apply_s = 1'b0;
        flush_apply_s = 1'b0;
        if (rst) begin
            state_next_s = RUN;
        end else if (flush) begin
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            state_next_s  = FLUSH;
            fcnt_next_s   = FLUSH_LOAD;
            flush_apply_s = 1'b1;
        end else if (load_stall) begin
            // A stall also drops any remaining flush-hold cycles
            pc_we         = 1'b0;
            ifid_we       = 1'b0;
            idex_bubble   = 1'b1;
            state_next_s  = STALL;
            scnt_next_s   = (scnt_r == 8'hFF) ? scnt_r : (scnt_r + 8'd1);
            stall_apply_s = 1'b1;
        end else if ((state_r == FLUSH) && (fcnt_r != 4'd0)) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            state_next_s = FLUSH;
            fcnt_next_s  = fcnt_r - 4'd1;
        end else begin
            state_next_s = RUN;
        end
    end

    // Timeout fires on the stall cycle that brings the consecutive count up to the limit
    assign timeout_set_s = stall_apply_s && (({1'b0, scnt_r} + 9'd1) >= STALL_LIMIT);

    // State, hold counters, sticky timeout and saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= RUN;
            fcnt_r         <= 4'd0;
            scnt_r         <= 8'd0;
            timeout_r      <= 1'b0;
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_events_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            fcnt_r  <= fcnt_next_s;
            scnt_r  <= scnt_next_s;
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
            if (stall_apply_s && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_apply_s && (flush_events_r != CNT_MAX)) begin
                flush_events_r <= flush_events_r + CNT_ONE;
            end else begin
                flush_events_r <= flush_events_r;
            end
        end
    end

    assign ctrl_state    = state_r;
    assign stall_timeout = timeout_r;
    assign stall_cycles  = stall_cycles_r;
    assign flush_events  = flush_events_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver queues hand-computed per-cycle expectations,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       load_stall;
    logic       flush;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] ctrl_state;
    logic       stall_timeout;
    logic [3:0] stall_cycles;
    logic [3:0] flush_events;

    int checks;
    int errors;

    logic [14:0] exp_q[$];
    string       name_q[$];

    pipe_ctrl #(
        .FLUSH_LEN(2),
        .STALL_MAX(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_stall(load_stall),
        .flush(flush),
        .pc_we(pc_we),
        .ifid_we(ifid_we),
        .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble),
        .ctrl_state(ctrl_state),
        .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble}; values are those seen during this cycle
    task automatic step(input string nm, input logic r, input logic ls, input logic fl,
                        input logic [3:0] ctl, input logic [1:0] st, input logic to,
                        input logic [3:0] sc, input logic [3:0] fe);
        @(posedge clk);
        #1;
        rst        = r;
        load_stall = ls;
        flush      = fl;
        exp_q.push_back({ctl, st, to, sc, fe});
        name_q.push_back(nm);
    endtask

    // Monitor: compare one queued expectation per falling edge
    initial begin
        logic [14:0] exp_v;
        logic [14:0] act_v;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {pc_we, ifid_we, ifid_flush, idex_bubble, ctrl_state,
                         stall_timeout, stall_cycles, flush_events};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got ctl=%b st=%0d to=%b sc=%0d fe=%0d, want ctl=%b st=%0d to=%b sc=%0d fe=%0d",
                             nm, act_v[14:11], act_v[10:9], act_v[8], act_v[7:4], act_v[3:0],
                             exp_v[14:11], exp_v[10:9], exp_v[8], exp_v[7:4], exp_v[3:0]);
                end
            end
        end
    end

    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0001;
    localparam logic [3:0] C_FLUSH = 4'b1111;

    // Driver: directed vectors with hand-derived expectations
    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        load_stall = 1'b0;
        flush      = 1'b0;

        step("reset_idle",      1'b1, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("reset_override",  1'b1, 1'b1, 1'b1, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("run_idle",        1'b0, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("single_stall",    1'b0, 1'b1, 1'b0, C_STALL, 2'd0, 1'b0, 4'd0, 4'd0);
        step("stall_release",   1'b0, 1'b0, 1'b0, C_RUN,   2'd1, 1'b0, 4'd1, 4'd0);
        step("flush_req",       1'b0, 1'b0, 1'b1, C_FLUSH, 2'd0, 1'b0, 4'd1, 4'd0);
        step("flush_hold",      1'b0, 1'b0, 1'b0, C_FLUSH, 2'd2, 1'b0, 4'd1, 4'd1);
        step("flush_exit",      1'b0, 1'b0, 1'b0, C_RUN,   2'd2, 1'b0, 4'd1, 4'd1);
        step("run_after_flush", 1'b0, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd1, 4'd1);
        step("simultaneous",    1'b0, 1'b1, 1'b1, C_FLUSH, 2'd0, 1'b0, 4'd1, 4'd1);
        step("stall_aborts",    1'b0, 1'b1, 1'b0, C_STALL, 2'd2, 1'b0, 4'd1, 4'd2);
        step("flush_in_stall",  1'b0, 1'b0, 1'b1, C_FLUSH, 2'd1, 1'b0, 4'd2, 4'd2);
        step("flush_in_flush",  1'b0, 1'b0, 1'b1, C_FLUSH, 2'd2, 1'b0, 4'd2, 4'd3);
        step("reload_hold",     1'b0, 1'b0, 1'b0, C_FLUSH, 2'd2, 1'b0, 4'd2, 4'd4);
        step("reload_exit",     1'b0, 1'b0, 1'b0, C_RUN,   2'd2, 1'b0, 4'd2, 4'd4);

        // Six consecutive stalls against a limit of four
        step("to_stall1",       1'b0, 1'b1, 1'b0, C_STALL, 2'd0, 1'b0, 4'd2, 4'd4);
        step("to_stall2",       1'b0, 1'b1, 1'b0, C_STALL, 2'd1, 1'b0, 4'd3, 4'd4);
        step("to_stall3",       1'b0, 1'b1, 1'b0, C_STALL, 2'd1, 1'b0, 4'd4, 4'd4);
        step("to_stall4",       1'b0, 1'b1, 1'b0, C_STALL, 2'd1, 1'b0, 4'd5, 4'd4);
        step("to_stall5",       1'b0, 1'b1, 1'b0, C_STALL, 2'd1, 1'b1, 4'd6, 4'd4);
        step("to_stall6",       1'b0, 1'b1, 1'b0, C_STALL, 2'd1, 1'b1, 4'd7, 4'd4);
        step("to_release",      1'b0, 1'b0, 1'b0, C_RUN,   2'd1, 1'b1, 4'd8, 4'd4);
        step("to_sticky",       1'b0, 1'b0, 1'b0, C_RUN,   2'd0, 1'b1, 4'd8, 4'd4);

        // Reset mid-flush, then reset mid-stall
        step("mf_flush",        1'b0, 1'b0, 1'b1, C_FLUSH, 2'd0, 1'b1, 4'd8, 4'd4);
        step("mf_reset",        1'b1, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("mf_reset_hold",   1'b1, 1'b1, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("mf_release",      1'b0, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("ms_stall",        1'b0, 1'b1, 1'b0, C_STALL, 2'd0, 1'b0, 4'd0, 4'd0);
        step("ms_reset",        1'b1, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);
        step("ms_release",      1'b0, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd0);

        // Twenty back-to-back flushes: flush_events saturates at 15
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat_flush%0d", i), 1'b0, 1'b0, 1'b1, C_FLUSH,
                 (i == 0) ? 2'd0 : 2'd2, 1'b0, 4'd0, (i > 15) ? 4'd15 : 4'(i));
        end
        step("sat_flush_hold",  1'b0, 1'b0, 1'b0, C_FLUSH, 2'd2, 1'b0, 4'd0, 4'd15);
        step("sat_flush_exit",  1'b0, 1'b0, 1'b0, C_RUN,   2'd2, 1'b0, 4'd0, 4'd15);
        step("sat_flush_run",   1'b0, 1'b0, 1'b0, C_RUN,   2'd0, 1'b0, 4'd0, 4'd15);

        // Eighteen stalls: stall_cycles saturates at 15, timeout after the fourth
        for (int i = 0; i < 18; i++) begin
            step($sformatf("sat_stall%0d", i), 1'b0, 1'b1, 1'b0, C_STALL,
                 (i == 0) ? 2'd0 : 2'd1, (i >= 4) ? 1'b1 : 1'b0,
                 (i > 15) ? 4'd15 : 4'(i), 4'd15);
        end
        step("sat_stall_end",   1'b0, 1'b0, 1'b0, C_RUN,   2'd1, 1'b1, 4'd15, 4'd15);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
